// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Imported by the control FSM and its opcode classifier.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Opcode classifier: picks the state that follows DECODE.
// Unknown opcodes route to HALT and are flagged illegal.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic [5:0] opcode,
  output state_t     dec_state,
  output logic       dec_illegal
);

  always_comb begin
    dec_state   = S_HALT;
    dec_illegal = 1'b0;
    // The halt opcode wins even if it aliases a real instruction.
    if (opcode == HALT_OPCODE) begin
      dec_state = S_HALT;
    end else begin
      unique case (opcode)
        OP_RTYPE: dec_state = S_R_EXEC;
        OP_LW:    dec_state = S_MEM_ADDR;
        OP_SW:    dec_state = S_MEM_ADDR;
        OP_BEQ:   dec_state = S_BRANCH;
        OP_ADDI:  dec_state = S_I_EXEC;
        OP_J:     dec_state = S_JUMP;
        default: begin
          dec_state   = S_HALT;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch through write-back
// over one shared memory port and counts retired instructions.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halt,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  state_t           dec_state;
  logic             dec_illegal;
  logic             ill_q;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            c;

  mips_ctrl_decode #(
    .HALT_OPCODE(HALT_OPCODE)
  ) u_decode (
    .opcode     (opcode),
    .dec_state  (dec_state),
    .dec_illegal(dec_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ill_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      ill_q <= dec_illegal;
    end
  end

  // Saturating: the counter parks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (retire && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_state;
      S_MEM_ADDR: begin
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Selects are pure state decode; only ir_we/pc_we see the inputs.
  always_comb begin
    c = '0;
    unique case (state_q)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
        c.ir_we     = mem_ready;
        c.pc_we     = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 1'b1;
      end
      S_I_WB: c.reg_we = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
        c.pc_we     = zero;
      end
      S_JUMP: begin
        c.pc_we  = 1'b1;
        c.pc_src = PC_JUMP;
      end
      default: c = '0;
    endcase
  end

  assign mem_req    = c.mem_req;
  assign mem_we     = c.mem_we;
  assign iord       = c.iord;
  assign ir_we      = c.ir_we;
  assign pc_we      = c.pc_we;
  assign pc_src     = c.pc_src;
  assign reg_we     = c.reg_we;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign alu_op     = c.alu_op;
  assign halt       = (state_q == S_HALT);
  assign illegal    = ill_q;
  assign state      = state_q;
  assign retired    = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed table,
// random instruction stream and hand-written corner sequences.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic mem_req, mem_we, iord, ir_we, pc_we;
  logic reg_we, reg_dst, mem_to_reg, alu_src_a, halt, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;
  logic [31:0] retired;

  logic q_mem_req, q_mem_we, q_iord, q_ir_we, q_pc_we;
  logic q_reg_we, q_reg_dst, q_mem_to_reg, q_alu_src_a, q_halt, q_illegal;
  logic [1:0] q_pc_src, q_alu_src_b, q_alu_op;
  logic [3:0] q_state;
  logic [3:0] q_retired;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .halt(halt), .illegal(illegal), .state(state), .retired(retired)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(q_mem_req), .mem_we(q_mem_we),
    .iord(q_iord), .ir_we(q_ir_we), .pc_we(q_pc_we),
    .pc_src(q_pc_src), .reg_we(q_reg_we), .reg_dst(q_reg_dst),
    .mem_to_reg(q_mem_to_reg), .alu_src_a(q_alu_src_a),
    .alu_src_b(q_alu_src_b), .alu_op(q_alu_op), .halt(q_halt),
    .illegal(q_illegal), .state(q_state), .retired(q_retired)
  );

  always #5 clk = ~clk;

  logic [19:0] act;
  assign act = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src,
                reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_op, halt};

  int n_vec = 0;
  int n_err = 0;
  int exp_ret = 0;
  int exp_q[$];

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         cyc;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B ||
           op == 6'h04 || op == 6'h08 || op == 6'h02;
  endfunction

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      6'h00, 6'h08, 6'h2B: return 4;
      6'h23:               return 5;
      6'h04, 6'h02:        return 3;
      default:             return 2;
    endcase
  endfunction

  // Expected state walk of one instruction, with memory stalls.
  function automatic void build_seq(input logic [5:0] op,
                                    input int fw, input int mw);
    exp_q.delete();
    repeat (fw + 1) exp_q.push_back(1);
    exp_q.push_back(2);
    case (op)
      6'h00: begin exp_q.push_back(7); exp_q.push_back(8); end
      6'h23: begin
        exp_q.push_back(3);
        repeat (mw + 1) exp_q.push_back(4);
        exp_q.push_back(5);
      end
      6'h2B: begin
        exp_q.push_back(3);
        repeat (mw + 1) exp_q.push_back(6);
      end
      6'h04: exp_q.push_back(9);
      6'h08: begin exp_q.push_back(11); exp_q.push_back(12); end
      6'h02: exp_q.push_back(10);
      default: ;
    endcase
  endfunction

  function automatic logic [19:0] exp_word(input int st, input logic rdy,
                                           input logic z);
    logic mr, mw, io, ir, pw, rw, rd, m2r, sa, h;
    logic [1:0] ps, sb, ao;
    mr = 0; mw = 0; io = 0; ir = 0; pw = 0; rw = 0; rd = 0;
    m2r = 0; sa = 0; h = 0; ps = 0; sb = 0; ao = 0;
    case (st)
      1: begin mr = 1; sb = 2'd1; ir = rdy; pw = rdy; end
      2: sb = 2'd3;
      3, 11: begin sa = 1; sb = 2'd2; end
      4: begin mr = 1; io = 1; end
      5: begin rw = 1; m2r = 1; end
      6: begin mr = 1; mw = 1; io = 1; end
      7: begin sa = 1; ao = 2'd2; end
      8: begin rw = 1; rd = 1; end
      9: begin sa = 1; ao = 2'd1; ps = 2'd1; pw = z; end
      10: begin pw = 1; ps = 2'd2; end
      12: rw = 1;
      13: h = 1;
      default: ;
    endcase
    return {4'(st), mr, mw, io, ir, pw, ps, rw, rd, m2r, sa, sb, ao, h};
  endfunction

  // Entry and exit: just after a falling edge with state FETCH.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int fw, input int mw, output int meas);
    int  fl, ml, k, es;
    logic rdy, done, left;
    build_seq(op, fw, mw);
    opcode = op; zero = z;
    fl = fw; ml = mw; k = 0; done = 0; left = 0;
    while (!done && k < 40) begin
      if (state == 4'd1) begin
        rdy = (fl == 0); if (fl > 0) fl--;
      end else if (state == 4'd4 || state == 4'd6) begin
        rdy = (ml == 0); if (ml > 0) ml--;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      mem_ready = rdy;
      #1;
      es = (k < exp_q.size()) ? exp_q[k] : 15;
      chk("cycle", act, exp_word(es, rdy, z));
      k++;
      @(negedge clk);
      if (state != 4'd1) left = 1;
      if ((left && state == 4'd1) || state == 4'd13) done = 1;
    end
    chk("no_timeout", done, 1);
    meas = k;
    chk("end_state", state, is_legal(op) ? 4'd1 : 4'd13);
    if (is_legal(op)) exp_ret++;
    chk("retired", retired, exp_ret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; mem_ready = 1;
    #1;
    chk("reset_outs", act, 0);
    chk("reset_flags", {illegal, retired}, 0);
    exp_ret = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("idle_to_fetch", state, 4'd1);
  endtask

  initial begin
    int meas, fw, mw, opi;
    logic [5:0] ops[6];
    logic [5:0] op;
    logic z;

    tbl[0] = '{6'h00, 1'b0, 0, 0, 4};
    tbl[1] = '{6'h23, 1'b0, 0, 2, 7};
    tbl[2] = '{6'h23, 1'b1, 0, 0, 5};
    tbl[3] = '{6'h2B, 1'b0, 1, 1, 6};
    tbl[4] = '{6'h04, 1'b1, 0, 0, 3};
    tbl[5] = '{6'h04, 1'b0, 0, 0, 3};
    tbl[6] = '{6'h08, 1'b1, 0, 0, 4};
    tbl[7] = '{6'h02, 1'b0, 2, 0, 5};
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h02;

    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, meas);
      chk("latency", meas, tbl[i].cyc);
    end

    for (int i = 0; i < 60; i++) begin
      opi = $urandom_range(0, 5);
      op = ops[opi];
      z = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      run_instr(op, z, fw, mw, meas);
      chk("rand_latency", meas, base_cycles(op) + fw +
          ((op == 6'h23 || op == 6'h2B) ? mw : 0));
    end

    // Asynchronous reset while a store is stalled.
    opcode = 6'h2B; zero = 0; mem_ready = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("sw_stall_state", state, 4'd6);
    chk("sw_stall_req", {mem_req, mem_we, iord}, 3'b111);
    #2;
    rst = 0;
    #1;
    chk("rst_mid_req", {mem_req, mem_we}, 2'b00);
    chk("rst_mid_state", state, 4'd0);
    chk("rst_mid_retired", retired, 0);
    exp_ret = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_fetch", state, 4'd1);

    run_instr(6'h3F, 1'b0, 0, 0, meas);
    chk("halt_latency", meas, 2);
    chk("halt_flags", {halt, illegal}, 2'b10);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_hold", {state, mem_req, halt, illegal}, {4'd13, 3'b010});
    end

    do_reset();
    run_instr(6'h11, 1'b0, 1, 0, meas);
    chk("illegal_latency", meas, 3);
    chk("illegal_flags", {halt, illegal}, 2'b11);
    @(negedge clk);
    chk("illegal_hold", {state, halt, illegal}, {4'd13, 2'b11});

    do_reset();
    for (int i = 1; i <= 17; i++) begin
      run_instr(6'h02, 1'b0, 0, 0, meas);
      chk("sat4", q_retired, (i > 15) ? 15 : i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
